// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues reads to a 1-cycle synchronous
// instruction memory and buffers returned words in a prefetch FIFO for decode.
module fetch_stage #(
    parameter int unsigned    PC_W       = 32,
    parameter int unsigned    FIFO_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst_out,
    output logic [PC_W-1:0] inst_pc
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  inflight_pc;
    logic             inflight;
    logic [31:0]      word_mem [FIFO_DEPTH];
    logic [PC_W-1:0]  pc_mem   [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   committed;
    logic             pop;
    logic             push;
    logic             issue;
    logic             not_empty;

    always_comb begin
        not_empty  = (count != '0);
        inst_valid = not_empty & ~branch_taken;
        pop        = inst_valid & inst_ready;
        push       = inflight & ~branch_taken & ~reset;
        // Slots already spoken for: buffered words plus the response still in flight.
        committed  = {1'b0, count} + (CNT_W + 1)'(inflight) - (CNT_W + 1)'(pop);
        issue      = ~reset & ~branch_taken & (committed < (CNT_W + 1)'(FIFO_DEPTH));
        imem_req   = issue;
        imem_addr  = pc;
        inst_out   = not_empty ? word_mem[rd_ptr] : '0;
        inst_pc    = not_empty ? pc_mem[rd_ptr]   : '0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            word_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]   <= inflight_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (branch_taken) begin
            pc       <= branch_target;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc          <= pc + PC_W'(1);
                inflight_pc <= pc;
            end
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage of the 32-bit pipelined processor, directly upstream of decode.
- Owns the PC and issues word-addressed reads to the synchronous instruction memory, which has 1-cycle read latency.
- Buffers returned instructions in a small prefetch FIFO and presents them to decode through a valid/ready handshake.
- Accepts taken-branch redirects from the branch unit and flushes all wrong-path instructions.

Parameters:
PC_W, 32, width of PC and memory address; word-addressed, so the PC increments by 1.
FIFO_DEPTH, 4, prefetch buffer entries; power of 2, minimum 2.
RESET_PC, 0, PC value after reset.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
imem_req  output  1  read request to instruction memory this cycle
imem_addr  output  PC_W  word address of the request; equals current PC
imem_rdata  input  32  instruction word, valid the cycle after an accepted request
branch_taken  input  1  redirect pulse from branch unit
branch_target  input  PC_W  redirect address, sampled when branch_taken=1
inst_valid  output  1  FIFO head holds a valid instruction
inst_ready  input  1  decode accepts the head this cycle
inst_out  output  32  head instruction word
inst_pc  output  PC_W  address the head instruction was fetched from

Behaviour:
- Reset, sampled on clk edge, overrides everything:
  - pc=RESET_PC; FIFO emptied; in-flight request cleared.
  - imem_req=0, inst_valid=0, inst_out=0, inst_pc=0.
  - Reset asserted mid-operation discards all buffered and in-flight instructions with no partial state.
- Internal state:
  - pc.
  - FIFO of {word, pc} pairs with read/write pointers and occupancy count (0..FIFO_DEPTH).
  - inflight bit: a request was issued last cycle.
  - inflight_pc.
- Pop: inst_valid & inst_ready, where inst_valid = (occupancy != 0) & ~branch_taken.
- Issue condition: occupancy + inflight - pop < FIFO_DEPTH, and branch_taken=0, and reset=0.
  - When issuing: imem_req=1, imem_addr=pc; on the edge, pc <= pc+1 (wraps modulo 2^PC_W), inflight <= 1, inflight_pc <= pc.
  - When not issuing: imem_req=0, inflight <= 0.
- Response: if inflight=1 at a clock edge (and no flush), {imem_rdata, inflight_pc} is written at the FIFO tail.
  - The issue condition guarantees a free slot for the write; overflow is impossible.
  - Simultaneous push and pop on a full-at-start FIFO is legal.
- Latency:
  - First cycle with reset low: request to RESET_PC.
  - Next cycle: data captured.
  - Following cycle: inst_valid=1. Reset-release to first valid is 2 cycles.
- Throughput: 1 instruction/cycle sustained while inst_ready=1.
- Backpressure: with inst_ready=0, the FIFO fills to FIFO_DEPTH, then imem_req drops. inst_out/inst_pc hold steady while inst_valid=1 and not popped.
- Branch (branch_taken=1 in cycle B):
  - Cycle B: inst_valid forced 0, so no transfer occurs; imem_req=0.
  - Edge ending B: FIFO emptied, inflight cleared (the response arriving in B+1 for a pre-branch request is discarded), pc <= branch_target.
  - Cycle B+1: request to branch_target. Cycle B+3: inst_valid with inst_pc=branch_target.
  - A back-to-back branch in B+1 supersedes the first and uses the newer target.
  - Reset takes priority over branch_taken.
- Wrap-around: pc at 2^PC_W-1 increments to 0 with no flag. FIFO pointers wrap modulo FIFO_DEPTH.

Test Plan:
1. Memory preloaded 0:4C00000C, 1:4C400001, 2:48800000; reset 2 cycles then low; inst_ready=1 -> imem_addr 0,1,2 on consecutive cycles; inst_valid rises 2 cycles after reset release; inst_out/inst_pc sequence (4C00000C,0),(4C400001,1),(48800000,2), one per cycle with no bubbles.
2. Backpressure: inst_ready=0 after release -> occupancy reaches 4 holding PCs 0..3; imem_req=0 thereafter; inst_out stable at 4C00000C; assert inst_ready -> PCs 0,1,2,3,4... in order, with no duplicates or gaps.
3. Branch while streaming: branch_taken=1, branch_target=3 when the head is PC 6 -> no transfer that cycle; next request address 3; next valid inst_pc=3 (10448000) 3 cycles after the pulse; no PC 6..9 words delivered.
4. Branch while stalled and full (inst_ready=0, occupancy 4) -> all 4 entries dropped; next delivered inst_pc=branch_target.
5. Back-to-back branches to 8 then 3 -> only PC 3 onward delivered.
6. Reset asserted mid-stream with occupancy 3 and a request in flight -> next cycle inst_valid=0, imem_req=0; after release, fetch restarts at 0 with the same latency as scenario 1.
